if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch front end, directly upstream of the instruction memory.
- Owns the program counter and drives the byte address into the IMEM.
- Aligns the IMEM's one-cycle registered-read data with the PC that produced it.
- Absorbs decode-stage stalls with a one-entry hold buffer, applies branch/jump redirects, and presents {if_pc, if_inst, if_valid} to the IF/ID register.

Parameters:
- bits, 32, instruction width (matches IMEM data width).
- addr_width, 12, byte-address width of IMEM / PC.
- RESET_PC, 0, PC value loaded on reset (lower 2 bits must be 0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  addr_width  byte address to IMEM; IMEM returns data one clk later.
- imem_inst  input  bits  IMEM read data for the address sampled at the previous edge.
- stall  input  1  decode not ready; hold the current fetch outputs.
- redirect  input  1  branch/jump taken; discard the in-flight fetch.
- redirect_target  input  addr_width  new PC when redirect=1.
- if_pc  output  addr_width  PC of the instruction on if_inst.
- if_inst  output  bits  fetched instruction.
- if_valid  output  1  if_pc/if_inst hold a real instruction.

Behaviour:
- Reset: one clock; rst is asynchronous, active-high, and clears all state immediately regardless of clk.
  - Reset values: pc_q=RESET_PC, f_pc_q=0, f_valid_q=0, hold_q=0, hold_valid_q=0.
  - Outputs during reset: imem_addr=RESET_PC, if_pc=0, if_valid=0, if_inst=imem_inst.
  - First cycle after rst release: if_valid=0. Next cycle: if_valid=1, if_inst=mem[RESET_PC].
- Registers: pc_q is the address presented now; f_pc_q is the PC whose data is on imem_inst now; f_valid_q; hold_q/hold_valid_q form the stall buffer.
- Combinational outputs:
  - imem_addr=pc_q.
  - if_pc=f_pc_q.
  - if_valid=f_valid_q.
  - if_inst = hold_valid_q ? hold_q : imem_inst.
- Advance (redirect=0, stall=0), each edge:
  - pc_q<=pc_q+4, wrapping modulo 2^addr_width (all-ones-region+4 wraps to 0, no flag).
  - f_pc_q<=pc_q, f_valid_q<=1, hold_valid_q<=0.
- Stall (redirect=0, stall=1):
  - pc_q, f_pc_q and f_valid_q hold.
  - If hold_valid_q=0: hold_q<=imem_inst and hold_valid_q<=1. This is needed because the IMEM samples pc_q this edge and its output would otherwise move to the next instruction.
  - If hold_valid_q=1: hold_q holds.
  - if_inst therefore remains the stalled instruction for any stall length.
- Stall release:
  - The held instruction is consumed on the edge where stall=0.
  - At that edge, f_pc_q<=pc_q and hold_valid_q<=0.
  - The next cycle shows mem[pc_q] live from the IMEM, with no gap and no duplicate.
- Redirect (priority over stall):
  - pc_q<={redirect_target[addr_width-1:2],2'b00}.
  - f_valid_q<=0, hold_valid_q<=0, f_pc_q<=pc_q (don't-care).
  - The cycle after redirect has if_valid=0 (one bubble). The following cycle shows if_valid=1, if_pc=target, if_inst=mem[target].
- Redirect with stall=1: redirect wins; the held instruction is discarded.
- Back-to-back redirects: the latest target wins; if_valid stays 0 until one non-redirect cycle elapses.
- Redirect during the first cycle after reset: legal, same rules apply.
- Throughput: one instruction per clk when not stalled or redirected.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Without the macro:
  - redirect_target[1:0] is silently forced to 00.
  - No extra port.
- With the macro:
  - Adds output if_misalign (1 bit, reset 0).
  - if_misalign is registered: it goes high for exactly the one cycle after a redirect whose redirect_target[1:0]!=00, aligned with the bubble (if_valid=0).
  - Aligned redirects and non-redirect cycles drive it 0.
  - PC truncation is unchanged.

Test Plan:
- Reset then free-run, RESET_PC=0, mem[i]=0x1000+i:
  - Cycle 1 after release: if_valid=0.
  - Cycles 2..5: if_pc=0,4,8,C with if_inst=0x1000..0x1003.
  - imem_addr leads if_pc by 4.
- Stall for 3 cycles while if_pc=0x8:
  - if_inst=0x1002 and if_pc=0x8 for all 4 cycles.
  - After release: if_pc=0xC with if_inst=0x1003, then 0x10 with 0x1004; no skip or repeat.
- Redirect to 0x40 while if_pc=0x10:
  - Next cycle if_valid=0.
  - Then if_pc=0x40 with if_inst=mem[0x10], then 0x44.
- Redirect and stall asserted together while holding:
  - hold is discarded and if_valid=0 next cycle.
  - Then if_pc=target; the stalled instruction is never re-emitted.
- Wrap: addr_width=12, redirect to 0xFFC:
  - Sequence if_pc=0xFFC, 0x000, 0x004.
- Assert rst mid-stall with hold_valid=1:
  - Immediate if_valid=0 and imem_addr=RESET_PC without a clock.
  - Sequence restarts as in test 1.
  - With FETCH_MISALIGN_CHK_EN, a redirect to 0x42 gives if_misalign=1 for one cycle, then if_pc=0x40.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - IMEM and decode-side signal bundle for if_fetch_unit
// if_misalign exists only when FETCH_MISALIGN_CHK_EN is defined.
interface if_fetch_unit_if #(
  parameter int bits       = 32,
  parameter int addr_width = 12
);
  logic [addr_width-1:0] imem_addr;
  logic [bits-1:0]       imem_inst;
  logic                  stall;
  logic                  redirect;
  logic [addr_width-1:0] redirect_target;
  logic [addr_width-1:0] if_pc;
  logic [bits-1:0]       if_inst;
  logic                  if_valid;
`ifdef FETCH_MISALIGN_CHK_EN
  logic                  if_misalign;
`endif

  modport master (
    output imem_addr,
    input  imem_inst,
    input  stall,
    input  redirect,
    input  redirect_target,
    output if_pc,
    output if_inst,
`ifdef FETCH_MISALIGN_CHK_EN
    output if_misalign,
`endif
    output if_valid
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    output stall,
    output redirect,
    output redirect_target,
    input  if_pc,
    input  if_inst,
`ifdef FETCH_MISALIGN_CHK_EN
    input  if_misalign,
`endif
    input  if_valid
  );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - PC owner, IMEM read alignment, stall hold buffer and redirect
// Optional FETCH_MISALIGN_CHK_EN adds a registered if_misalign flag on unaligned redirects.
module if_fetch_unit #(
  parameter int                    bits       = 32,
  parameter int                    addr_width = 12,
  parameter logic [addr_width-1:0] RESET_PC   = '0
) (
  input logic             clk,
  input logic             rst,
  if_fetch_unit_if.master bus
);
  localparam logic [addr_width-1:0] PC_STEP    = addr_width'(4);
  localparam logic [addr_width-1:0] ALIGN_MASK = ~addr_width'(3);

  logic [addr_width-1:0] pc_q;
  logic [addr_width-1:0] f_pc_q;
  logic                  f_valid_q;
  logic [bits-1:0]       hold_q;
  logic                  hold_valid_q;
  logic [addr_width-1:0] target_aligned;

  assign target_aligned = bus.redirect_target & ALIGN_MASK;

  // Redirect outranks stall; a stall only captures IMEM data once, on its first edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      f_pc_q       <= '0;
      f_valid_q    <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else if (bus.redirect) begin
      pc_q         <= target_aligned;
      f_pc_q       <= pc_q;
      f_valid_q    <= 1'b0;
      hold_valid_q <= 1'b0;
    end else if (bus.stall) begin
      if (!hold_valid_q) begin
        hold_q       <= bus.imem_inst;
        hold_valid_q <= 1'b1;
      end
    end else begin
      pc_q         <= pc_q + PC_STEP;
      f_pc_q       <= pc_q;
      f_valid_q    <= 1'b1;
      hold_valid_q <= 1'b0;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.if_pc     = f_pc_q;
  assign bus.if_valid  = f_valid_q;
  assign bus.if_inst   = hold_valid_q ? hold_q : bus.imem_inst;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= bus.redirect && (bus.redirect_target[1:0] != 2'b00);
    end
  end

  assign bus.if_misalign = misalign_q;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed-vector bench for if_fetch_unit with a registered-read IMEM model
module tb_if_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] mem [0:1023];

  if_fetch_unit_if #(.bits(32), .addr_width(12)) bus ();

  if_fetch_unit #(.bits(32), .addr_width(12), .RESET_PC(12'h000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.imem_inst <= mem[bus.imem_addr[11:2]];

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    check_eq({tag, " valid"}, 32'(bus.if_valid), 32'd1);
    check_eq({tag, " pc"}, 32'(bus.if_pc), pc);
    check_eq({tag, " inst"}, bus.if_inst, inst);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + 32'(i);
    bus.stall           = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = '0;
    bus.imem_inst       = '0;

    #1;
    check_eq("rst valid", 32'(bus.if_valid), 32'd0);
    check_eq("rst pc", 32'(bus.if_pc), 32'd0);
    check_eq("rst addr", 32'(bus.imem_addr), 32'd0);
    step();
    step();
    rst = 1'b0;

    // Free run from RESET_PC
    check_eq("first valid", 32'(bus.if_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      expect_fetch("run", 32'(4 * k), 32'h1000 + 32'(k));
      check_eq("run addr lead", 32'(bus.imem_addr), 32'(4 * k + 4));
    end

    // Three-cycle stall on if_pc=0x8
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_fetch("stall", 32'h8, 32'h1002);
    end
    bus.stall = 1'b0;
    step();
    expect_fetch("release0", 32'hC, 32'h1003);
    step();
    expect_fetch("release1", 32'h10, 32'h1004);

    // Redirect to 0x40
    bus.redirect = 1'b1;
    bus.redirect_target = 12'h040;
    step();
    bus.redirect = 1'b0;
    check_eq("redir bubble", 32'(bus.if_valid), 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
    check_eq("aligned misalign", 32'(bus.if_misalign), 32'd0);
`endif
    step();
    expect_fetch("redir0", 32'h40, 32'h1010);
    step();
    expect_fetch("redir1", 32'h44, 32'h1011);

    // Redirect together with stall while the hold buffer is full
    bus.stall = 1'b1;
    step();
    expect_fetch("hold", 32'h44, 32'h1011);
    bus.redirect = 1'b1;
    bus.redirect_target = 12'h080;
    step();
    bus.redirect = 1'b0;
    bus.stall = 1'b0;
    check_eq("rs bubble", 32'(bus.if_valid), 32'd0);
    step();
    expect_fetch("rs0", 32'h80, 32'h1020);
    step();
    expect_fetch("rs1", 32'h84, 32'h1021);

    // Back-to-back redirects: latest target wins
    bus.redirect = 1'b1;
    bus.redirect_target = 12'h100;
    step();
    bus.redirect_target = 12'h200;
    step();
    check_eq("b2b bubble", 32'(bus.if_valid), 32'd0);
    bus.redirect = 1'b0;
    step();
    expect_fetch("b2b", 32'h200, 32'h1080);

    // Wrap at the top of the 12-bit space
    bus.redirect = 1'b1;
    bus.redirect_target = 12'hFFC;
    step();
    bus.redirect = 1'b0;
    step();
    expect_fetch("wrap0", 32'hFFC, 32'h13FF);
    step();
    expect_fetch("wrap1", 32'h000, 32'h1000);
    step();
    expect_fetch("wrap2", 32'h004, 32'h1001);

    // Unaligned redirect target is truncated
    bus.redirect = 1'b1;
    bus.redirect_target = 12'h042;
    step();
    bus.redirect = 1'b0;
    check_eq("mis bubble", 32'(bus.if_valid), 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
    check_eq("misalign hi", 32'(bus.if_misalign), 32'd1);
`endif
    step();
    expect_fetch("mis", 32'h40, 32'h1010);
`ifdef FETCH_MISALIGN_CHK_EN
    check_eq("misalign lo", 32'(bus.if_misalign), 32'd0);
`endif

    // Asynchronous reset mid-stall with the hold buffer full
    bus.stall = 1'b1;
    step();
    expect_fetch("pre rst hold", 32'h40, 32'h1010);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async valid", 32'(bus.if_valid), 32'd0);
    check_eq("async addr", 32'(bus.imem_addr), 32'd0);
    check_eq("async pc", 32'(bus.if_pc), 32'd0);
    step();
    rst = 1'b0;
    bus.stall = 1'b0;
    check_eq("restart bubble", 32'(bus.if_valid), 32'd0);
    step();
    expect_fetch("restart0", 32'h0, 32'h1000);
    step();
    expect_fetch("restart1", 32'h4, 32'h1001);

    // Redirect in the first cycle after reset release
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_target = 12'h020;
    step();
    bus.redirect = 1'b0;
    check_eq("early bubble", 32'(bus.if_valid), 32'd0);
    step();
    expect_fetch("early", 32'h20, 32'h1008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
